// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared types for the BCD conversion arbiter.
// Holds the FSM state encoding and the operand/result widths.
package bcd_conv_arbiter_pkg;

    localparam int OP_W  = 8;
    localparam int BCD_W = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Requester-side bus of the BCD conversion arbiter.
// master: drives req/bin_in, sees gnt/ack/bcd_out/owner/busy. slave: the arbiter.
interface bcd_conv_arbiter_if
    import bcd_conv_arbiter_pkg::*;
#(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]      req;
    logic [OP_W*N_REQ-1:0] bin_in;
    logic [N_REQ-1:0]      gnt;
    logic [N_REQ-1:0]      ack;
    logic [BCD_W-1:0]      bcd_out;
    logic [1:0]            owner;
    logic                  busy;

    modport master (
        output req, bin_in,
        input  gnt, ack, bcd_out, owner, busy
    );

    modport slave (
        input  req, bin_in,
        output gnt, ack, bcd_out, owner, busy
    );
endinterface

// File: rtl/bcd_conv_arbiter_bin_to_bcd.sv
// Combinational 8-bit binary to 3-digit BCD converter (double dabble).
// Ports: i_bin (8-bit binary), o_bcd {hundreds[1:0], tens[3:0], ones[3:0]}.
module bin_to_bcd
    import bcd_conv_arbiter_pkg::*;
(
    input  logic [OP_W-1:0]  i_bin,
    output logic [BCD_W-1:0] o_bcd
);
    logic [17:0] w_sh;

    always_comb begin
        w_sh = {10'd0, i_bin};
        for (int i = 0; i < OP_W; i++) begin
            // hundreds never exceeds 2 for 8-bit input, so only two columns adjust
            if (w_sh[11:8] >= 4'd5)
                w_sh[11:8] = w_sh[11:8] + 4'd3;
            if (w_sh[15:12] >= 4'd5)
                w_sh[15:12] = w_sh[15:12] + 4'd3;
            w_sh = w_sh << 1;
        end
        o_bcd = w_sh[17:8];
    end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one binary-to-BCD converter among N_REQ requesters (IDLE->CONV->DONE).
// Ports: clk, rst_n (sync, active low), bus (slave: req, bin_in, gnt, ack,
// bcd_out, owner, busy). Macro BCD_ARB_FIXED_PRI_EN gives requester 0 priority.
module bcd_conv_arbiter
    import bcd_conv_arbiter_pkg::*;
#(
    parameter int N_REQ = 3
)(
    input  logic              clk,
    input  logic              rst_n,
    bcd_conv_arbiter_if.slave bus
);
    state_t             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_ack;
    logic [BCD_W-1:0]   r_bcd;
    logic [1:0]         r_owner;
    logic [1:0]         r_gidx;
    logic [1:0]         r_last;
    logic               r_busy;
    logic [OP_W-1:0]    r_op;

    logic [3:0]         w_req4;
    logic               w_any;
    logic               w_found;
    logic [2:0]         w_sum;
    logic [1:0]         w_win;
    logic [N_REQ-1:0]   w_oh;
    logic [OP_W-1:0]    w_op;
    logic [BCD_W-1:0]   w_bcd;

    // pad to 4 so 2-bit indices are always in range
    assign w_req4 = 4'(bus.req);
    assign w_any  = |bus.req;

    // round-robin: first requester after last_served, wrapping mod N_REQ
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            w_sum = {1'b0, r_last} + 3'(off);
            if (w_sum >= 3'(N_REQ))
                w_sum = w_sum - 3'(N_REQ);
            if (!w_found && w_req4[w_sum[1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[1:0];
            end
        end
`ifdef BCD_ARB_FIXED_PRI_EN
        // req[0] overrides; otherwise the RR result never picks 0
        if (w_req4[0])
            w_win = 2'd0;
`endif
    end

    always_comb begin
        w_oh = '0;
        w_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == 2'(i)) begin
                w_oh[i] = 1'b1;
                w_op    = bus.bin_in[OP_W*i +: OP_W];
            end
        end
    end

    bin_to_bcd u_conv (
        .i_bin (r_op),
        .o_bcd (w_bcd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_bcd   <= '0;
            r_owner <= '0;
            r_gidx  <= '0;
            r_last  <= 2'(N_REQ - 1);
            r_busy  <= 1'b0;
            r_op    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_ack <= '0;
                    if (w_any) begin
                        r_gnt   <= w_oh;
                        r_gidx  <= w_win;
                        r_op    <= w_op;
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (w_req4[r_gidx]) begin
                        r_bcd   <= w_bcd;
                        r_owner <= r_gidx;
                        r_last  <= r_gidx;
                        r_ack   <= r_gnt;
                        r_state <= S_DONE;
                    end else begin
                        // owner withdrew: drop silently, keep old result
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_ack   <= '0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.ack     = r_ack;
    assign bus.bcd_out = r_bcd;
    assign bus.owner   = r_owner;
    assign bus.busy    = r_busy;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed testbench for bcd_conv_arbiter (N_REQ=3).
// Honours BCD_ARB_FIXED_PRI_EN when choosing contention expectations.
module tb_bcd_conv_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    bcd_conv_arbiter_if #(.N_REQ(3)) bus ();

    bcd_conv_arbiter #(.N_REQ(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.req    = '0;
        bus.bin_in = '0;
        tick();
        tick();
        n_cmp++;
        if ({bus.gnt, bus.ack, bus.busy} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctl got gnt=%b ack=%b busy=%b want 0",
                     bus.gnt, bus.ack, bus.busy);
        end
        n_cmp++;
        if ({bus.bcd_out, bus.owner} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_data got bcd=%h owner=%0d want 0",
                     bus.bcd_out, bus.owner);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.req    = 3'b001;
        bus.bin_in = {8'd0, 8'd0, 8'd255};
        tick();
        n_cmp++;
        if (bus.gnt !== 3'b001 || bus.ack !== 3'b000 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_gnt got gnt=%b ack=%b busy=%b want 001/000/1",
                     bus.gnt, bus.ack, bus.busy);
        end
        tick();
        n_cmp++;
        if (bus.ack !== 3'b001) begin
            n_err++;
            $display("FAIL single_ack got %b want 001", bus.ack);
        end
        n_cmp++;
        if (bus.bcd_out !== 10'b10_0101_0101 || bus.owner !== 2'd0) begin
            n_err++;
            $display("FAIL single_bcd got %h/%0d want 255/0",
                     bus.bcd_out, bus.owner);
        end
        bus.req = '0;
        tick();
        n_cmp++;
        if (bus.ack !== 3'b000 || bus.gnt !== 3'b000 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_end got gnt=%b ack=%b busy=%b want 0",
                     bus.gnt, bus.ack, bus.busy);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] ops [6];
        logic [9:0] exp [6];
        ops = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199};
        exp = '{10'h000, 10'h009, 10'h010, 10'h099, 10'h100, 10'h199};
        for (int k = 0; k < 6; k++) begin
            bus.req    = 3'b100;
            bus.bin_in = {ops[k], 8'hAA, 8'h55};
            tick();
            // operand must already be captured at grant
            bus.bin_in = {8'hFF, 8'hAA, 8'h55};
            tick();
            n_cmp++;
            if (bus.ack !== 3'b100 || bus.bcd_out !== exp[k] ||
                bus.owner !== 2'd2) begin
                n_err++;
                $display("FAIL bound_%0d got ack=%b bcd=%h own=%0d want 100/%h/2",
                         ops[k], bus.ack, bus.bcd_out, bus.owner, exp[k]);
            end
            bus.req = '0;
            tick();
            n_cmp++;
            if (bus.ack !== 3'b000) begin
                n_err++;
                $display("FAIL bound_pulse_%0d got ack=%b want 000",
                         ops[k], bus.ack);
            end
        end
    endtask

    task automatic test_contention();
        int         ord [4];
        logic [9:0] tab [3];
        int         idx;
        tab = '{10'h012, 10'h034, 10'h056};
`ifdef BCD_ARB_FIXED_PRI_EN
        ord = '{0, 0, 0, 0};
`else
        ord = '{0, 1, 2, 0};
`endif
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        bus.req    = 3'b111;
        bus.bin_in = {8'd56, 8'd34, 8'd12};
        for (int t = 1; t <= 12; t++) begin
            tick();
            n_cmp++;
            if (t % 3 == 2) begin
                idx = ord[(t - 2) / 3];
                if (bus.ack !== 3'(1 << idx) || bus.bcd_out !== tab[idx] ||
                    bus.owner !== 2'(idx)) begin
                    n_err++;
                    $display("FAIL cont_t%0d got ack=%b bcd=%h own=%0d want %0d/%h",
                             t, bus.ack, bus.bcd_out, bus.owner, idx, tab[idx]);
                end
            end else begin
                if (bus.ack !== 3'b000) begin
                    n_err++;
                    $display("FAIL cont_gap_t%0d got ack=%b want 000",
                             t, bus.ack);
                end
            end
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_abandon();
        bus.req    = 3'b010;
        bus.bin_in = {8'd5, 8'd77, 8'd3};
        tick();
        n_cmp++;
        if (bus.gnt !== 3'b010) begin
            n_err++;
            $display("FAIL aband_gnt got %b want 010", bus.gnt);
        end
        bus.req = 3'b000;
        tick();
        n_cmp++;
        if (bus.ack !== 3'b000 || bus.busy !== 1'b0 || bus.gnt !== 3'b000) begin
            n_err++;
            $display("FAIL aband_ctl got ack=%b busy=%b gnt=%b want 0",
                     bus.ack, bus.busy, bus.gnt);
        end
        n_cmp++;
        if (bus.bcd_out !== 10'h012 || bus.owner !== 2'd0) begin
            n_err++;
            $display("FAIL aband_hold got %h/%0d want 012/0",
                     bus.bcd_out, bus.owner);
        end
        bus.req = 3'b110;
        tick();
        n_cmp++;
        if (bus.gnt !== 3'b010) begin
            n_err++;
            $display("FAIL aband_next got %b want 010", bus.gnt);
        end
        tick();
        n_cmp++;
        if (bus.ack !== 3'b010 || bus.bcd_out !== 10'h077 ||
            bus.owner !== 2'd1) begin
            n_err++;
            $display("FAIL aband_serve got ack=%b bcd=%h own=%0d want 010/077/1",
                     bus.ack, bus.bcd_out, bus.owner);
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.req    = 3'b010;
        bus.bin_in = {8'd0, 8'd42, 8'd0};
        tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({bus.gnt, bus.ack, bus.busy, bus.bcd_out, bus.owner} !== 19'b0) begin
            n_err++;
            $display("FAIL rmid_zero got gnt=%b ack=%b busy=%b bcd=%h own=%0d",
                     bus.gnt, bus.ack, bus.busy, bus.bcd_out, bus.owner);
        end
        tick();
        n_cmp++;
        if (bus.ack !== 3'b000) begin
            n_err++;
            $display("FAIL rmid_noack got %b want 000", bus.ack);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.gnt !== 3'b010 || bus.ack !== 3'b000) begin
            n_err++;
            $display("FAIL rmid_gnt got gnt=%b ack=%b want 010/000",
                     bus.gnt, bus.ack);
        end
        tick();
        n_cmp++;
        if (bus.ack !== 3'b010 || bus.bcd_out !== 10'h042 ||
            bus.owner !== 2'd1) begin
            n_err++;
            $display("FAIL rmid_ack got ack=%b bcd=%h own=%0d want 010/042/1",
                     bus.ack, bus.bcd_out, bus.owner);
        end
        bus.req = '0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_boundaries();
        test_contention();
        test_abandon();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3, number of requesters (legal 2..4).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port req, input, N_REQ, per-requester conversion request, level, held until ack.
REQ-005 The block SHALL have port bin_in, input, 8*N_REQ, packed operands; requester i uses bits [8i+7:8i].
REQ-006 The block SHALL have port gnt, output, N_REQ, one-hot grant, high for the conversion owner.
REQ-007 The block SHALL have port ack, output, N_REQ, one-cycle completion pulse to the owner.
REQ-008 The block SHALL have port bcd_out, output, 10, registered BCD result {hundreds[1:0], tens[3:0], ones[3:0]}.
REQ-009 The block SHALL have port owner, output, 2, index of the requester whose result is in bcd_out.
REQ-010 The block SHALL have port busy, output, 1, high when not in IDLE.

Function
REQ-011 The block SHALL share one 8-bit binary-to-BCD converter among N_REQ requesters via FSM IDLE -> CONV -> DONE -> IDLE.
REQ-012 In IDLE with any req bit high at an edge, the block SHALL select a winner, set gnt one-hot, latch its operand into op_q and enter CONV.
REQ-013 In CONV, at the next edge, the block SHALL register converter(op_q) into bcd_out, set owner, pulse ack of the owner and enter DONE.
REQ-014 The DONE state SHALL last exactly one cycle; ack high only during DONE; gnt held through CONV and DONE, cleared on return to IDLE.
REQ-015 Latency SHALL be: req sampled at edge k, ack high in the cycle after edge k+1; minimum spacing between grants 3 cycles.
REQ-016 Arbitration SHALL be round-robin: search starts at last_served+1 modulo N_REQ; last_served updates only on a completed ack.
REQ-017 Operand SHALL be sampled only at grant; later bin_in changes SHALL NOT affect the result.
REQ-018 If req[owner] is low at the CONV edge, the block SHALL abandon: no ack, bcd_out/owner/last_served unchanged, go to IDLE.
REQ-019 bcd_out and owner SHALL hold their value until the next completed conversion.
REQ-020 A requester holding req after its ack SHALL be re-eligible and served again only after other pending requesters (no starvation).
REQ-021 Bits of req at indices >= N_REQ are nonexistent; unused owner bits SHALL read 0.

Reset
REQ-022 With rst_n low at an edge: state=IDLE, gnt=0, ack=0, bcd_out=0, owner=0, busy=0, op_q=0, last_served=N_REQ-1 (requester 0 wins first).
REQ-023 Reset asserted during CONV or DONE SHALL cancel the conversion; no ack is issued afterward.

Configuration
REQ-024 Macro BCD_ARB_FIXED_PRI_EN defined: requester 0 SHALL win whenever req[0] is high at arbitration; others round-robin among themselves.
REQ-025 Macro BCD_ARB_FIXED_PRI_EN undefined: pure round-robin per REQ-016 for all requesters.

Structure
REQ-026 Shared package SHALL hold the FSM state encoding (IDLE, CONV, DONE), BCD width 10, operand width 8.
REQ-027 The converter SHALL be the existing bin_to_bcd sub-module, instantiated once, fed from op_q; no other sub-module.

Verification
REQ-028 Single request: req=001, bin_in[7:0]=255 -> gnt=001 one cycle later, ack=001 pulse next cycle, bcd_out=10'b10_0101_0101, owner=0.
REQ-029 Boundaries: operands 0, 9, 10, 99, 100, 199 -> bcd_out 000, 009, 010, 099, 100, 199 (BCD), each ack one cycle.
REQ-030 Contention: req=111 held, operands 12/34/56 -> acks in order 0,1,2,0 with bcd_out 012, 034, 056, 012; 3-cycle spacing.
REQ-031 Abandon: req[1] dropped during CONV -> no ack, bcd_out unchanged, busy low next cycle, next arbitration starts at 1.
REQ-032 Reset mid-CONV with req=010 -> all outputs 0 after edge, no ack; after release requester 1 served with ack 2 cycles later.
REQ-033 With BCD_ARB_FIXED_PRI_EN: req=111 held -> requester 0 served every grant; without it, order per REQ-030.
